alu_pipe: RTL and testbench
===========================

// Module: alu_pipe
// PURPOSE
//   Parametrised, pipelined integer ALU that replaces the single-function combinational
//   units (alu_xor and its siblings) with one multi-op block. Operands enter through a
//   valid/ready handshake and pass through a STAGES-deep register pipeline with full
//   backpressure. Results leave with a zero flag, an illegal-op flag and a running
//   completed-operation count. The block sits between the decode/issue stage and writeback.
// PARAMETERS
//   XLEN    32  operand/result width in bits; legal range 8..64, power of two
//   STAGES  2   pipeline depth in register stages; legal range 1..4
//   CNTW    16  width of the ops_done counter
// PORTS
//   clk         in   1        rising-edge clock
//   rst_n       in   1        asynchronous, active-low reset
//   in_valid    in   1        op, rs1 and rs2 are valid this cycle
//   in_ready    out  1        block can accept an input this cycle
//   op          in   4        operation select (see BEHAVIOUR)
//   rs1         in   XLEN     operand 1
//   rs2         in   XLEN     operand 2; bits [log2(XLEN)-1:0] give the shift amount
//   out_valid   out  1        rd, zero and err are valid
//   out_ready   in   1        consumer accepts the output this cycle
//   rd          out  XLEN     result
//   zero        out  1        asserted when rd == 0
//   err         out  1        op was not a legal encoding
//   ops_done    out  CNTW     count of output transfers; wraps modulo 2^CNTW
// BEHAVIOUR
//   - Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
//     While rst_n=0: every stage valid bit, out_valid, rd, zero, err and ops_done are 0.
//     in_ready is 1 in the first cycle after reset is released.
//   - Ops: 0 ADD, 1 SUB, 2 XOR, 3 OR, 4 AND, 5 SLL, 6 SRL, 7 SRA,
//     8 SLT (signed, result 0 or 1), 9 SLTU (unsigned, result 0 or 1).
//     Any other encoding (10..15): rd=0, zero=1, err=1.
//   - Arithmetic: ADD and SUB wrap modulo 2^XLEN; no carry or overflow output.
//     Shifts use only rs2[log2(XLEN)-1:0]; the upper bits of rs2 are ignored.
//   - Datapath: the result is computed combinationally from the inputs and captured in
//     stage 0. Stages 1..STAGES-1 are pure delay registers, each with its own valid bit.
//   - Handshake: advance = ~v[STAGES-1] | out_ready; in_ready = advance.
//     - An input is accepted on any clock edge where in_valid & in_ready.
//     - When advance=1, every stage shifts forward and stage 0 loads v=in_valid.
//     - When advance=0, every stage holds its contents.
//     - out_valid = v[STAGES-1]. rd, zero and err come from the last stage.
//   - Latency: an input accepted at edge N appears with out_valid=1 after edge N+STAGES-1
//     when there is no backpressure.
//   - Throughput: 1 op per cycle while out_ready=1.
//   - Ordering: results leave in acceptance order. No result is dropped or duplicated.
//   - Stall stability: while out_valid=1 and out_ready=0, rd, zero and err stay constant.
//   - Bubbles: empty stages shift forward and collapse even while out_ready=0, but only if
//     the last stage is empty.
//   - Counter: ops_done increments on every edge where out_valid & out_ready.
//     It wraps from 2^CNTW-1 to 0 with no flag.
//   - Reset mid-operation: all in-flight ops are discarded immediately.
//     After release, out_valid=0 until new inputs propagate through the pipe.
// TESTING
//   1. XOR sweep at STAGES=2, out_ready=1, one op per cycle:
//      (0,0)->0, zero=1; (0,FFFFFFFF)->FFFFFFFF; (FFFFFFFF,0)->FFFFFFFF;
//      (FFFFFFFF,FFFFFFFF)->0, zero=1. Each result appears 2 edges after its input,
//      in order, and ops_done ends at 4.
//   2. Arithmetic and shift edges:
//      ADD FFFFFFFF+1 -> 0, zero=1; SUB 0-1 -> FFFFFFFF;
//      SRA 80000000 by rs2=0x21 -> C0000000 (shift amount 1);
//      SLT(FFFFFFFF,1) -> 1; SLTU(FFFFFFFF,1) -> 0.
//   3. Backpressure: stream 6 ADDs (i+i) with out_ready low for cycles 3..7.
//      in_ready drops once the pipe is full; rd is held; results 0,2,4,6,8,10 arrive
//      with none lost; ops_done=6.
//   4. Illegal op=12 -> rd=0, zero=1, err=1, and the following legal op has err=0.
//   5. Reset mid-operation: assert rst_n=0 with 2 ops in flight. out_valid=0 at once;
//      after release, ops_done=0 and a new XOR(A5A5A5A5,FFFFFFFF) -> 5A5A5A5A.
//   6. Parameter sweep XLEN=8/64 × STAGES=1/4:
//      latency equals STAGES; SLL by XLEN-1 of 1 gives MSB only; CNTW=4 wraps 15->0.

Source files
------------

// File: rtl/alu_pipe_if.sv
// rtl/alu_pipe_if.sv - issue-side and writeback-side handshake bundle for the ALU pipe
interface alu_pipe_if #(
   parameter int XLEN = 32,
   parameter int CNTW = 16
);
   logic            in_valid;
   logic            in_ready;
   logic [3:0]      op;
   logic [XLEN-1:0] rs1;
   logic [XLEN-1:0] rs2;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] rd;
   logic            zero;
   logic            err;
   logic [CNTW-1:0] ops_done;

   modport master (
      output in_valid, op, rs1, rs2, out_ready,
      input  in_ready, out_valid, rd, zero, err, ops_done
   );

   modport slave (
      input  in_valid, op, rs1, rs2, out_ready,
      output in_ready, out_valid, rd, zero, err, ops_done
   );
endinterface

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - pipelined multi-op integer ALU with valid/ready backpressure
// Result is formed combinationally into stage 0; later stages only delay it.
module alu_pipe #(
   parameter int XLEN   = 32,
   parameter int STAGES = 2,
   parameter int CNTW   = 16
) (
   input logic       clk,
   input logic       rst_n,
   alu_pipe_if.slave bus
);
   localparam int SHW = $clog2(XLEN);

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_XOR  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_AND  = 4'd4;
   localparam logic [3:0] OP_SLL  = 4'd5;
   localparam logic [3:0] OP_SRL  = 4'd6;
   localparam logic [3:0] OP_SRA  = 4'd7;
   localparam logic [3:0] OP_SLT  = 4'd8;
   localparam logic [3:0] OP_SLTU = 4'd9;

   logic [SHW-1:0]  shamt;
   logic [XLEN-1:0] res;
   logic            res_err;

   logic [STAGES-1:0] v_q, v_d;
   logic [STAGES-1:0] zero_q, zero_d;
   logic [STAGES-1:0] err_q, err_d;
   logic [XLEN-1:0]   rd_q [STAGES];
   logic [XLEN-1:0]   rd_d [STAGES];
   logic [CNTW-1:0]   ops_done_q, ops_done_d;
   logic              advance;

   assign shamt = bus.rs2[SHW-1:0];

   always_comb begin
      res     = '0;
      res_err = 1'b0;
      case (bus.op)
         OP_ADD:  res = bus.rs1 + bus.rs2;
         OP_SUB:  res = bus.rs1 - bus.rs2;
         OP_XOR:  res = bus.rs1 ^ bus.rs2;
         OP_OR:   res = bus.rs1 | bus.rs2;
         OP_AND:  res = bus.rs1 & bus.rs2;
         OP_SLL:  res = bus.rs1 << shamt;
         OP_SRL:  res = bus.rs1 >> shamt;
         OP_SRA:  res = $signed(bus.rs1) >>> shamt;
         OP_SLT:  res = {{(XLEN-1){1'b0}}, ($signed(bus.rs1) < $signed(bus.rs2))};
         OP_SLTU: res = {{(XLEN-1){1'b0}}, (bus.rs1 < bus.rs2)};
         default: res_err = 1'b1;
      endcase
   end

   // The pipe moves as a whole; an empty last stage lets bubbles collapse under stall.
   always_comb begin
      advance    = ~v_q[STAGES-1] | bus.out_ready;
      v_d        = v_q;
      zero_d     = zero_q;
      err_d      = err_q;
      rd_d       = rd_q;
      ops_done_d = ops_done_q;
      if (advance) begin
         v_d[0]    = bus.in_valid;
         rd_d[0]   = res;
         zero_d[0] = (res == '0);
         err_d[0]  = res_err;
         for (int i = 1; i < STAGES; i++) begin
            v_d[i]    = v_q[i-1];
            rd_d[i]   = rd_q[i-1];
            zero_d[i] = zero_q[i-1];
            err_d[i]  = err_q[i-1];
         end
      end
      if (v_q[STAGES-1] && bus.out_ready) begin
         ops_done_d = ops_done_q + CNTW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_q        <= '0;
         zero_q     <= '0;
         err_q      <= '0;
         ops_done_q <= '0;
         for (int i = 0; i < STAGES; i++) begin
            rd_q[i] <= '0;
         end
      end else begin
         v_q        <= v_d;
         zero_q     <= zero_d;
         err_q      <= err_d;
         ops_done_q <= ops_done_d;
         rd_q       <= rd_d;
      end
   end

   assign bus.in_ready  = advance;
   assign bus.out_valid = v_q[STAGES-1];
   assign bus.rd        = rd_q[STAGES-1];
   assign bus.zero      = zero_q[STAGES-1];
   assign bus.err       = err_q[STAGES-1];
   assign bus.ops_done  = ops_done_q;
endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - directed self-checking bench for alu_pipe
module tb_alu_pipe;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   alu_pipe_if #(.XLEN(32), .CNTW(16)) bus ();
   alu_pipe_if #(.XLEN(8),  .CNTW(4))  b8 ();
   alu_pipe_if #(.XLEN(64), .CNTW(4))  b64 ();

   alu_pipe #(.XLEN(32), .STAGES(2), .CNTW(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   alu_pipe #(.XLEN(8),  .STAGES(1), .CNTW(4))  u8  (.clk(clk), .rst_n(rst_n), .bus(b8));
   alu_pipe #(.XLEN(64), .STAGES(4), .CNTW(4))  u64 (.clk(clk), .rst_n(rst_n), .bus(b64));

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] c;
      logic [31:0] r;
      logic        z;
      logic        e;
   } vec_t;

   vec_t        tv[$];
   int          cyc;
   int          n_chk = 0;
   int          n_bad = 0;
   int          last_base;
   int          last_pbase;
   logic [31:0] got_rd[$];
   logic        got_z[$];
   logic        got_e[$];
   int          got_cyc[$];
   int          pres_cyc[$];
   int          stall_cnt;
   int          hold_bad;
   logic        prev_stall;
   logic [31:0] prev_rd;

   always @(posedge clk) cyc <= cyc + 1;

   // Output collector: a transfer happens at the next rising edge when valid & ready here.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (bus.out_valid && bus.out_ready) begin
            got_rd.push_back(bus.rd);
            got_z.push_back(bus.zero);
            got_e.push_back(bus.err);
            got_cyc.push_back(cyc);
         end
         if (!bus.in_ready) stall_cnt <= stall_cnt + 1;
         if (prev_stall === 1'b1 && bus.rd !== prev_rd) hold_bad <= hold_bad + 1;
      end
      prev_stall <= rst_n && bus.out_valid && !bus.out_ready;
      prev_rd    <= bus.rd;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_all();
      bus.in_valid = 1'b0;
      b8.in_valid  = 1'b0;
      b64.in_valid = 1'b0;
   endtask

   task automatic do_reset();
      idle_all();
      rst_n = 1'b0;
      step();
      step();
      @(negedge clk);
      rst_n = 1'b1;
      step();
   endtask

   task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] c);
      bit acc = 1'b0;
      bus.in_valid = 1'b1;
      bus.op       = op;
      bus.rs1      = a;
      bus.rs2      = c;
      pres_cyc.push_back(cyc);
      for (int i = 0; i < 50 && !acc; i++) begin
         @(negedge clk);
         acc = bus.in_ready;
         step();
      end
      if (!acc) check("send_timeout", 64'd0, 64'd1);
   endtask

   task automatic drain(input int want);
      for (int i = 0; i < 40 && got_rd.size() < want; i++) step();
      step();
      if (got_rd.size() < want) check("drain_timeout", 64'(got_rd.size()), 64'(want));
   endtask

   task automatic add(input logic [3:0] op, input logic [31:0] a, input logic [31:0] c,
                      input logic [31:0] r, input logic z, input logic e);
      vec_t v;
      v.op = op; v.a = a; v.c = c; v.r = r; v.z = z; v.e = e;
      tv.push_back(v);
   endtask

   task automatic run_vecs(input string tag);
      last_base  = got_rd.size();
      last_pbase = pres_cyc.size();
      foreach (tv[i]) send(tv[i].op, tv[i].a, tv[i].c);
      bus.in_valid = 1'b0;
      drain(last_base + tv.size());
      foreach (tv[i]) begin
         check($sformatf("%s%0d_rd", tag, i),   64'(got_rd[last_base+i]), 64'(tv[i].r));
         check($sformatf("%s%0d_zero", tag, i), 64'(got_z[last_base+i]),  64'(tv[i].z));
         check($sformatf("%s%0d_err", tag, i),  64'(got_e[last_base+i]),  64'(tv[i].e));
      end
   endtask

   initial begin
      int base, s0, h0, k, lat8, lat64;
      logic [7:0]  r8;
      logic [63:0] r64;

      rst_n = 1'b1;
      bus.in_valid = 1'b0; bus.op = 4'd0; bus.rs1 = '0; bus.rs2 = '0; bus.out_ready = 1'b1;
      b8.in_valid  = 1'b0; b8.op  = 4'd0; b8.rs1  = '0; b8.rs2  = '0; b8.out_ready  = 1'b1;
      b64.in_valid = 1'b0; b64.op = 4'd0; b64.rs1 = '0; b64.rs2 = '0; b64.out_ready = 1'b1;
      #2 rst_n = 1'b0;
      #10;
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_rd",        64'(bus.rd),        64'd0);
      check("rst_zero",      64'(bus.zero),      64'd0);
      check("rst_err",       64'(bus.err),       64'd0);
      check("rst_ops_done",  64'(bus.ops_done),  64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      check("rst_in_ready", 64'(bus.in_ready), 64'd1);

      // XOR sweep, back-to-back
      tv.delete();
      add(4'd2, 32'h0,        32'h0,        32'h0,        1'b1, 1'b0);
      add(4'd2, 32'h0,        32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0);
      add(4'd2, 32'hFFFFFFFF, 32'h0,        32'hFFFFFFFF, 1'b0, 1'b0);
      add(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        1'b1, 1'b0);
      run_vecs("xor");
      for (int i = 0; i < 4; i++)
         check($sformatf("xor%0d_lat", i),
               64'(got_cyc[last_base+i] - pres_cyc[last_pbase+i]), 64'd2);
      check("xor_ops_done", 64'(bus.ops_done), 64'd4);

      // arithmetic, logic and shift edges
      do_reset();
      tv.delete();
      add(4'd0, 32'hFFFFFFFF, 32'h1,        32'h0,        1'b1, 1'b0);
      add(4'd1, 32'h0,        32'h1,        32'hFFFFFFFF, 1'b0, 1'b0);
      add(4'd7, 32'h80000000, 32'h21,       32'hC0000000, 1'b0, 1'b0);
      add(4'd8, 32'hFFFFFFFF, 32'h1,        32'h1,        1'b0, 1'b0);
      add(4'd9, 32'hFFFFFFFF, 32'h1,        32'h0,        1'b1, 1'b0);
      add(4'd3, 32'hF0F00000, 32'h0000F0F0, 32'hF0F0F0F0, 1'b0, 1'b0);
      add(4'd4, 32'hFF00FF00, 32'h0F0F0F0F, 32'h0F000F00, 1'b0, 1'b0);
      add(4'd5, 32'h1,        32'h24,       32'h10,       1'b0, 1'b0);
      add(4'd6, 32'h80000000, 32'h1,        32'h40000000, 1'b0, 1'b0);
      run_vecs("arith");

      // backpressure: out_ready low for cycles 3..7 of the stream
      do_reset();
      base = got_rd.size();
      s0 = stall_cnt;
      h0 = hold_bad;
      fork
         begin
            for (int i = 0; i < 6; i++) send(4'd0, 32'(i), 32'(i));
            bus.in_valid = 1'b0;
         end
         begin
            repeat (3) step();
            bus.out_ready = 1'b0;
            repeat (5) step();
            bus.out_ready = 1'b1;
         end
      join
      drain(base + 6);
      for (int i = 0; i < 6; i++)
         check($sformatf("bp%0d_rd", i), 64'(got_rd[base+i]), 64'(2 * i));
      check("bp_count",      64'(got_rd.size() - base), 64'd6);
      check("bp_in_ready",   64'(stall_cnt > s0),       64'd1);
      check("bp_rd_held",    64'(hold_bad - h0),        64'd0);
      check("bp_ops_done",   64'(bus.ops_done),         64'd6);

      // illegal op followed by a legal one
      do_reset();
      tv.delete();
      add(4'd12, 32'h5, 32'h7, 32'h0, 1'b1, 1'b1);
      add(4'd0,  32'h1, 32'h2, 32'h3, 1'b0, 1'b0);
      run_vecs("illegal");

      // reset with two ops in flight
      do_reset();
      base = got_rd.size();
      send(4'd2, 32'h1, 32'h2);
      send(4'd2, 32'h3, 32'h4);
      bus.in_valid = 1'b0;
      check("mid_inflight", 64'(bus.out_valid), 64'd1);
      rst_n = 1'b0;
      #1;
      check("mid_out_valid", 64'(bus.out_valid), 64'd0);
      check("mid_ops_done",  64'(bus.ops_done),  64'd0);
      step();
      @(negedge clk);
      rst_n = 1'b1;
      step();
      step();
      step();
      check("post_out_valid", 64'(bus.out_valid),          64'd0);
      check("post_no_result", 64'(got_rd.size() - base),   64'd0);
      check("post_ops_done",  64'(bus.ops_done),           64'd0);
      tv.delete();
      add(4'd2, 32'hA5A5A5A5, 32'hFFFFFFFF, 32'h5A5A5A5A, 1'b0, 1'b0);
      run_vecs("post");

      // XLEN=8/STAGES=1 and XLEN=64/STAGES=4: latency and MSB shift
      do_reset();
      b8.op  = 4'd5; b8.rs1  = 8'h1;  b8.rs2  = 8'd7;
      b64.op = 4'd5; b64.rs1 = 64'h1; b64.rs2 = 64'd63;
      b8.in_valid  = 1'b1;
      b64.in_valid = 1'b1;
      k = cyc;
      lat8 = -1; lat64 = -1; r8 = '0; r64 = '0;
      for (int i = 0; i < 10; i++) begin
         step();
         b8.in_valid  = 1'b0;
         b64.in_valid = 1'b0;
         @(negedge clk);
         if (lat8 < 0 && b8.out_valid) begin lat8 = cyc - k; r8 = b8.rd; end
         if (lat64 < 0 && b64.out_valid) begin lat64 = cyc - k; r64 = b64.rd; end
      end
      check("x8_latency",  64'(lat8),  64'd1);
      check("x64_latency", 64'(lat64), 64'd4);
      check("x8_sll_msb",  64'(r8),    64'h80);
      check("x64_sll_msb", r64,        64'h8000000000000000);

      // 4-bit counter wrap
      do_reset();
      b8.op = 4'd0;
      b64.op = 4'd0;
      b8.in_valid  = 1'b1;
      b64.in_valid = 1'b1;
      repeat (15) step();
      idle_all();
      repeat (8) step();
      check("x8_cnt15",  64'(b8.ops_done),  64'd15);
      check("x64_cnt15", 64'(b64.ops_done), 64'd15);
      b8.in_valid  = 1'b1;
      b64.in_valid = 1'b1;
      step();
      idle_all();
      repeat (8) step();
      check("x8_wrap",  64'(b8.ops_done),  64'd0);
      check("x64_wrap", 64'(b64.ops_done), 64'd0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end
endmodule
